// File: rtl/vga_scanout.sv
// VGA raster timing generator with a small pixel FIFO in front of registered RGB444/sync pads.
// Optional build macro VGA_SCANOUT_TESTPAT_EN adds testpat_i, which replaces active pixels with 8 vertical colour bars.
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIX_DIV    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic        testpat_i,
`endif
    input  logic [11:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        frame_start_o,
    output logic        underrun_o,
    output logic [3:0]  R_o,
    output logic [3:0]  G_o,
    output logic [3:0]  B_o,
    output logic        hSYNC_o,
    output logic        vSYNC_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    logic [DW-1:0] div_reg;
    logic [HW-1:0] h_reg, h_next;
    logic [VW-1:0] v_reg, v_next;
    logic          enable_prev_reg;
    logic          tick, active, hs_on, vs_on;
    logic          frame_start_next, flush;

    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          full, empty, push, pop;
    logic [11:0]   pix_rgb;
    logic          starve;

    logic [11:0]   rgb_reg;
    logic          hsync_reg, vsync_reg, frame_start_reg, underrun_reg;

    assign tick   = (div_reg == DW'(PIX_DIV - 1));
    assign active = (h_reg < HW'(H_ACTIVE)) && (v_reg < VW'(V_ACTIVE));
    assign hs_on  = (h_reg >= HW'(H_ACTIVE + H_FP)) && (h_reg < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on  = (v_reg >= VW'(V_ACTIVE + V_FP)) && (v_reg < VW'(V_ACTIVE + V_FP + V_SYNC));

    always_comb begin
        h_next = h_reg + 1'b1;
        v_next = v_reg;
        if (h_reg == HW'(H_TOTAL - 1)) begin
            h_next = '0;
            v_next = (v_reg == VW'(V_TOTAL - 1)) ? '0 : v_reg + 1'b1;
        end
    end

    // A frame starts either on enable rising or when the raster wraps into vblank.
    assign frame_start_next = enable_i &&
        (!enable_prev_reg || (tick && h_next == '0 && v_next == VW'(V_ACTIVE)));
    assign flush = !enable_i || frame_start_next;

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= VW'(V_ACTIVE);
        end else if (tick) begin
            div_reg <= '0;
            h_reg   <= h_next;
            v_reg   <= v_next;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) enable_prev_reg <= 1'b0;
        else       enable_prev_reg <= enable_i;
    end

    assign full        = (count_reg == CW'(FIFO_DEPTH));
    assign empty       = (count_reg == '0);
    assign pix_ready_o = enable_i && !full;
    assign push        = pix_valid_i && pix_ready_o && !flush;
    assign pop         = enable_i && tick && active && !empty;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_reg] <= pix_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

`ifdef VGA_SCANOUT_TESTPAT_EN
    logic [2:0]  bar;
    logic [11:0] bar_rgb;
    assign bar     = 3'((32'(h_reg) * 8) / H_ACTIVE);
    assign bar_rgb = {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}};
`endif

    // Colour for an active tick; an empty FIFO shows black and counts as starvation.
    always_comb begin
        pix_rgb = empty ? 12'h000 : mem[rd_ptr_reg];
        starve  = empty;
`ifdef VGA_SCANOUT_TESTPAT_EN
        if (testpat_i) begin
            pix_rgb = bar_rgb;
            starve  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            rgb_reg         <= '0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            frame_start_reg <= frame_start_next;
            if (tick) begin
                hsync_reg <= hs_on ? SYNC_POL : ~SYNC_POL;
                vsync_reg <= vs_on ? SYNC_POL : ~SYNC_POL;
                rgb_reg   <= active ? pix_rgb : 12'h000;
                if (active && starve) underrun_reg <= 1'b1;
            end
        end
    end

    assign R_o           = rgb_reg[11:8];
    assign G_o           = rgb_reg[7:4];
    assign B_o           = rgb_reg[3:0];
    assign hSYNC_o       = hsync_reg;
    assign vSYNC_o       = vsync_reg;
    assign frame_start_o = frame_start_reg;
    assign underrun_o    = underrun_reg;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboarded bench for vga_scanout on a tiny 14x7 raster (PIX_DIV=2, 4-entry FIFO).
module tb_vga_scanout;
    localparam int PIX_DIV = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, enable_i, pix_valid_i;
    logic [11:0] pix_data_i;
    logic        pix_ready_o, frame_start_o, underrun_o, hSYNC_o, vSYNC_o;
    logic [3:0]  R_o, G_o, B_o;

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(PIX_DIV), .FIFO_DEPTH(4), .SYNC_POL(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
`ifdef VGA_SCANOUT_TESTPAT_EN
        .testpat_i(1'b0),
`endif
        .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .frame_start_o(frame_start_o), .underrun_o(underrun_o),
        .R_o(R_o), .G_o(G_o), .B_o(B_o), .hSYNC_o(hSYNC_o), .vSYNC_o(vSYNC_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    bit          src_en = 1'b0;
    bit          src_raw = 1'b0;
    int          src_limit = 32;
    int          raw_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel source: restarts at 1 on frame_start_o, pushes expected colour on each accepted beat.
    initial begin : source
        int val;
        bit armed, acc;
        val = 1; armed = 0; acc = 0;
        pix_valid_i = 1'b0;
        pix_data_i  = '0;
        forever begin
            @(negedge clk_i);
            if (src_raw) begin
                pix_valid_i = 1'b1;
                pix_data_i  = '0;
            end else if (!src_en) begin
                armed = 0;
                pix_valid_i = 1'b0;
            end else begin
                if (frame_start_o) begin
                    armed = 1;
                    val   = 1;
                end else if (acc) begin
                    val++;
                end
                pix_valid_i = armed && (val <= src_limit);
                pix_data_i  = 12'(val);
            end
            #1;
            acc = pix_valid_i && pix_ready_o;
            if (acc) begin
                if (src_raw) raw_acc++;
                else         exp_q.push_back(12'(val));
            end
        end
    end

    // Monitor: every new non-black colour is one displayed pixel; check its value and hold time.
    initial begin : monitor
        logic [11:0] cur, last;
        int hold;
        last = '0; hold = 0;
        forever begin
            @(negedge clk_i);
            cur = {R_o, G_o, B_o};
            if (rst_i || !enable_i) begin
                last = '0;
                hold = 0;
            end else if (cur != last) begin
                if (last != 12'h000) chk("pixel_hold", hold, PIX_DIV);
                if (cur != 12'h000) begin
                    if (exp_q.size() == 0) chk("pixel_unexpected", cur, 0);
                    else                   chk("pixel_value", cur, exp_q.pop_front());
                end
                last = cur;
                hold = 1;
            end else begin
                hold++;
            end
        end
    end

    task automatic start_frame(input string name);
        enable_i = 1'b1;
        @(negedge clk_i);
        chk(name, frame_start_o, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rgb"}, {R_o, G_o, B_o}, 0);
        chk({tag, "_hsync"}, hSYNC_o, 1);
        chk({tag, "_vsync"}, vSYNC_o, 1);
        chk({tag, "_ready"}, pix_ready_o, 0);
        chk({tag, "_fs"}, frame_start_o, 0);
        chk({tag, "_underrun"}, underrun_o, 0);
    endtask

    initial begin : main
        int hs_low, vs_low, first_act, first_hs, fs_cnt;
        rst_i = 1'b1;
        enable_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_idle("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Full frame of streamed pixels 0x001..0x020.
        src_en = 1'b1;
        src_limit = 32;
        start_frame("fs_enable_a");
        chk("ready_at_frame_start", pix_ready_o, 1);
        hs_low = 0; vs_low = 0; first_act = -1; first_hs = -1;
        for (int t = 0; t < 196; t++) begin
            if (t > 0) @(negedge clk_i);
            if (hSYNC_o == 1'b0) hs_low++;
            if (vSYNC_o == 1'b0) vs_low++;
            if (first_act < 0 && {R_o, G_o, B_o} != 12'h000) first_act = t;
            if (first_act >= 0 && first_hs < 0 && hSYNC_o == 1'b0) first_hs = t;
            if (t == 1)   chk("fs_pulse_width", frame_start_o, 0);
            if (t == 10)  chk("ready_full_in_vblank", pix_ready_o, 0);
            if (t == 186) src_en = 1'b0;
            if (t == 194) chk("fs_before_wrap", frame_start_o, 0);
            if (t == 195) chk("fs_frame_wrap", frame_start_o, 1);
        end
        chk("first_active_clk", first_act, 85);
        chk("hsync_after_active", first_hs - first_act, 20);
        chk("hsync_low_clks", hs_low, 28);
        chk("vsync_low_clks", vs_low, 28);
        chk("underrun_stream", underrun_o, 0);
        chk("scoreboard_drained_a", exp_q.size(), 0);
        enable_i = 1'b0;
        @(negedge clk_i);
        chk("disable_rgb", {R_o, G_o, B_o}, 0);
        chk("disable_ready", pix_ready_o, 0);

        // Source stops after 3 pixels: 4th active tick underruns.
        src_en = 1'b1;
        src_limit = 3;
        @(negedge clk_i);
        start_frame("fs_enable_b");
        for (int t = 0; t <= 150; t++) begin
            if (t > 0) @(negedge clk_i);
            if (t == 89) chk("underrun_before", underrun_o, 0);
            if (t == 91) begin
                chk("underrun_pixel_black", {R_o, G_o, B_o}, 0);
                chk("underrun_set", underrun_o, 1);
            end
            if (t == 150) chk("underrun_sticky", underrun_o, 1);
        end
        chk("scoreboard_drained_b", exp_q.size(), 0);
        src_en = 1'b0;
        enable_i = 1'b0;
        @(negedge clk_i);
        chk("underrun_cleared", underrun_o, 0);

        // Back-pressure and frame-start flush with an always-valid source.
        src_raw = 1'b1;
        @(negedge clk_i);
        start_frame("fs_enable_c");
        raw_acc = 0;
        for (int t = 0; t <= 195; t++) begin
            if (t > 0) @(negedge clk_i);
            if (t == 20) begin
                chk("ready_accepts", raw_acc, 4);
                chk("ready_low_full", pix_ready_o, 0);
            end
            if (t == 194) begin
                chk("ready_full_pre_flush", pix_ready_o, 0);
                chk("underrun_full_fifo", underrun_o, 0);
            end
            if (t == 195) begin
                chk("fs_flush", frame_start_o, 1);
                chk("ready_after_flush", pix_ready_o, 1);
                src_raw = 1'b0;
            end
        end
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset in the middle of line 2.
        src_en = 1'b1;
        src_limit = 32;
        @(negedge clk_i);
        start_frame("fs_enable_d");
        for (int t = 1; t <= 147; t++) @(negedge clk_i);
        rst_i = 1'b1;
        enable_i = 1'b0;
        src_en = 1'b0;
        @(negedge clk_i);
        chk_idle("rst_mid");
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        fs_cnt = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (frame_start_o) fs_cnt++;
        end
        chk("fs_quiet_after_reset", fs_cnt, 0);
        start_frame("fs_enable_e");
        @(negedge clk_i);
        chk("fs_pulse_width_e", frame_start_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
